// File: rtl/pdp8_seq_pkg.sv
// rtl/pdp8_seq_pkg.sv - shared state encoding and phase constants for the PDP-8 phase sequencer
package pdp8_seq_pkg;

    localparam int MAX_PHASES = 6;

    localparam logic [2:0] PHASE_IDLE = 3'd0;

    // CKn = 2n-1 (odd), STBn = 2n (even); the phase number falls out of (state+1)/2
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_CK1  = 4'd1,
        ST_STB1 = 4'd2,
        ST_CK2  = 4'd3,
        ST_STB2 = 4'd4,
        ST_CK3  = 4'd5,
        ST_STB3 = 4'd6,
        ST_CK4  = 4'd7,
        ST_STB4 = 4'd8,
        ST_CK5  = 4'd9,
        ST_STB5 = 4'd10,
        ST_CK6  = 4'd11,
        ST_STB6 = 4'd12
    } seq_state_t;

    function automatic logic [2:0] state_to_phase(input logic [3:0] s);
        logic [4:0] sum;
        sum = {1'b0, s} + 5'd1;
        return sum[3:1];
    endfunction

endpackage

// File: rtl/seq_phase_decode.sv
// rtl/seq_phase_decode.sv - combinational state to one-hot ck/stb strobes and phase number
module seq_phase_decode
    import pdp8_seq_pkg::*;
(
    input  logic [3:0]            i_state,
    output logic [MAX_PHASES-1:0] o_ck,
    output logic [MAX_PHASES-1:0] o_stb,
    output logic [2:0]            o_phase
);

    logic [2:0] w_phase;

    assign w_phase = state_to_phase(i_state);
    assign o_phase = w_phase;

    // IDLE maps to phase 0 and so never matches any strobe index
    always_comb begin
        o_ck  = '0;
        o_stb = '0;
        for (int i = 0; i < MAX_PHASES; i++) begin
            o_ck[i]  = i_state[0]  && (w_phase == 3'(i + 1));
            o_stb[i] = !i_state[0] && (w_phase == 3'(i + 1));
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - PDP-8 major-state sequencer: run/halt/step, instruction boundaries, timeout
// Optional CK-phase hold input wait_req enabled by PHASE_WAIT_EN.
module phase_sequencer
    import pdp8_seq_pkg::*;
#(
    parameter int NUM_PHASES = 6
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       halt_req,
    input  logic       step,
    input  logic       done,
    input  logic       tmo_clr,
`ifdef PHASE_WAIT_EN
    input  logic       wait_req,
`endif
    output logic       ck1,
    output logic       ck2,
    output logic       ck3,
    output logic       ck4,
    output logic       ck5,
    output logic       ck6,
    output logic       stb1,
    output logic       stb2,
    output logic       stb3,
    output logic       stb4,
    output logic       stb5,
    output logic       stb6,
    output logic       new_inst,
    output logic       running,
    output logic [2:0] phase,
    output logic       timeout
);

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic                   r_single;
    logic                   w_single_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;
    logic                   r_new_inst;
    logic                   w_new_inst_nxt;
    logic                   w_go;
    logic                   w_hold;
    logic                   w_last;
    logic [MAX_PHASES-1:0]  w_ck;
    logic [MAX_PHASES-1:0]  w_stb;
    logic [2:0]             w_phase;

`ifdef PHASE_WAIT_EN
    assign w_hold = wait_req;
`else
    assign w_hold = 1'b0;
`endif

    assign w_go   = run && !halt_req;
    assign w_last = (w_phase == 3'(NUM_PHASES));

    seq_phase_decode u_decode (
        .i_state (r_state),
        .o_ck    (w_ck),
        .o_stb   (w_stb),
        .o_phase (w_phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_single   <= 1'b0;
            r_timeout  <= 1'b0;
            r_new_inst <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_single   <= w_single_nxt;
            r_timeout  <= w_timeout_nxt;
            r_new_inst <= w_new_inst_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_single_nxt   = r_single;
        w_timeout_nxt  = tmo_clr ? 1'b0 : r_timeout;
        w_new_inst_nxt = 1'b0;
        if (r_state == ST_IDLE) begin
            if (!r_timeout && (w_go || step)) begin
                w_state_nxt    = ST_CK1;
                // a step alongside an effective run is just run
                w_single_nxt   = !w_go;
                w_new_inst_nxt = 1'b1;
            end
        end else if (r_state[0]) begin
            if (done) begin
                if (w_go && !r_single && !r_timeout) begin
                    w_state_nxt    = ST_CK1;
                    w_new_inst_nxt = 1'b1;
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_single_nxt = 1'b0;
                end
            end else if (!w_hold) begin
                w_state_nxt = seq_state_t'(r_state + 4'd1);
            end
        end else begin
            if (w_last) begin
                w_state_nxt   = ST_IDLE;
                w_single_nxt  = 1'b0;
                w_timeout_nxt = 1'b1;
            end else begin
                w_state_nxt = seq_state_t'(r_state + 4'd1);
            end
        end
    end

    assign ck1      = w_ck[0];
    assign ck2      = w_ck[1];
    assign ck3      = w_ck[2];
    assign ck4      = w_ck[3];
    assign ck5      = w_ck[4];
    assign ck6      = w_ck[5];
    assign stb1     = w_stb[0];
    assign stb2     = w_stb[1];
    assign stb3     = w_stb[2];
    assign stb4     = w_stb[3];
    assign stb5     = w_stb[4];
    assign stb6     = w_stb[5];
    assign phase    = w_phase;
    assign running  = (w_phase != PHASE_IDLE);
    assign new_inst = r_new_inst;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, halt_req, step, done, tmo_clr, wait_req;
    logic       ck1, ck2, ck3, ck4, ck5, ck6;
    logic       stb1, stb2, stb3, stb4, stb5, stb6;
    logic       new_inst, running, timeout;
    logic [2:0] phase;
    logic [17:0] w_obs;

    int n_checks = 0;
    int n_fail   = 0;

    string       q_tag[$];
    logic [17:0] q_exp[$];

    always #5 clk = ~clk;

    phase_sequencer #(.NUM_PHASES(6)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .halt_req (halt_req),
        .step     (step),
        .done     (done),
        .tmo_clr  (tmo_clr),
`ifdef PHASE_WAIT_EN
        .wait_req (wait_req),
`endif
        .ck1      (ck1),
        .ck2      (ck2),
        .ck3      (ck3),
        .ck4      (ck4),
        .ck5      (ck5),
        .ck6      (ck6),
        .stb1     (stb1),
        .stb2     (stb2),
        .stb3     (stb3),
        .stb4     (stb4),
        .stb5     (stb5),
        .stb6     (stb6),
        .new_inst (new_inst),
        .running  (running),
        .phase    (phase),
        .timeout  (timeout)
    );

    assign w_obs = {ck6, ck5, ck4, ck3, ck2, ck1, stb6, stb5, stb4, stb3, stb2, stb1,
                    new_inst, running, phase, timeout};

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // {ck6..ck1, stb6..stb1, new_inst, running, phase, timeout}
    function automatic logic [17:0] mk(input int p, input bit is_ck, input bit ni, input bit to);
        logic [5:0] one;
        one = (p > 0) ? 6'(1 << (p - 1)) : 6'd0;
        return {is_ck ? one : 6'd0, is_ck ? 6'd0 : one, ni, (p > 0), 3'(p), to};
    endfunction

    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) chk(q_tag.pop_front(), w_obs, q_exp.pop_front());
    end

    // drive inputs for the present cycle and queue the state expected after the next edge
    task automatic cyc(input bit r, input bit h, input bit s, input bit d, input bit c, input bit w,
                       input int p, input bit k, input bit ni, input bit to, input string tag);
        @(negedge clk);
        run = r; halt_req = h; step = s; done = d; tmo_clr = c; wait_req = w;
        q_tag.push_back(tag);
        q_exp.push_back(mk(p, k, ni, to));
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        run = 0; halt_req = 0; step = 0; done = 0; tmo_clr = 0; wait_req = 0;
        repeat (2) @(posedge clk);
        #1 chk("reset_state", w_obs, mk(0, 0, 0, 0));
        @(negedge clk) reset_n = 1'b1;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_hold");

        // run, done in CK2: CK1 STB1 CK2 repeating
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, "run_start_ck1");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "run_stb1");
            cyc(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, "run_ck2");
            cyc(1, 0, 0, 1, 0, 0, 1, 1, 1, 0, "run_b2b_ck1");
        end
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "run_stb1_last");
        cyc(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, "run_ck2_last");
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "run_stop_idle");

        // single step, done in CK3; a step mid-instruction is ignored
        cyc(0, 0, 1, 0, 0, 0, 1, 1, 1, 0, "step_ck1");
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "step_stb1");
        cyc(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, "step_ck2");
        cyc(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, "step_stb2");
        cyc(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, "step_ck3");
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "step_end_idle");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "step_no_requeue");

        // runaway instruction: 12 strobe cycles then timeout; tmo_clr in the same cycle loses
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, "tmo_ck1");
        for (int n = 1; n <= 6; n++) begin
            cyc(1, 0, 0, 0, 0, 0, n, 0, 0, 0, "tmo_stb");
            if (n < 6) cyc(1, 0, 0, 0, 0, 0, n + 1, 1, 0, 0, "tmo_ck");
        end
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, "tmo_set_wins");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "tmo_blocks_run");
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, "tmo_blocks_step");
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "tmo_cleared");
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, "tmo_restart_ck1");
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "done_in_ck1_idle");

        // halt raised in STB1 of a 3-phase instruction
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, "halt_ck1");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "halt_stb1");
        cyc(1, 1, 0, 0, 0, 0, 2, 1, 0, 0, "halt_ck2");
        cyc(1, 1, 0, 0, 0, 0, 2, 0, 0, 0, "halt_stb2");
        cyc(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, "halt_ck3");
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, "halt_idle");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "halt_stays_idle");

`ifdef PHASE_WAIT_EN
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, "wait_ck1");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, "wait_ck1_held");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "wait_stb1");
        cyc(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, "wait_ck2");
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "wait_done_wins");
`endif

        // asynchronous reset in STB2
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, "rst_ck1");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rst_stb1");
        cyc(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, "rst_ck2");
        cyc(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, "rst_stb2");
        reset_n = 1'b0;
        #1 chk("rst_async_drop", w_obs, mk(0, 0, 0, 0));
        @(negedge clk);
        run = 0;
        reset_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_release_idle");

        @(negedge clk);
        chk("sb_drained", 18'(q_exp.size()), 18'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
